// File: rtl/window_streamer.sv
// Captures a completed window from the windower and replays it one time slice per beat,
// oldest slice first, over a valid/ready stream. Windows arriving while busy are dropped and flagged.
module window_streamer #(
    parameter int NUM_CHS     = 2,
    parameter int WINDOW_SIZE = 4,
    parameter int SAMPLE_SIZE = 2
) (
    input  logic                                                 clk,
    input  logic                                                 nrst,
    input  logic                                                 window_valid,
    input  logic [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0] window,
    output logic                                                 window_ready,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0]                  out_slice,
    output logic [$clog2(WINDOW_SIZE)-1:0]                       out_idx,
    output logic                                                 out_last,
    output logic                                                 overrun,
    output logic                                                 busy
);

    localparam int IDX_W = $clog2(WINDOW_SIZE);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                                               state_q, state_d;
    logic [IDX_W-1:0]                                     idx_q, idx_d;
    logic [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0] win_q, win_d;
    logic                                                 overrun_q, overrun_d;

    logic stream_w;
    logic last_w;
    logic xfer_w;
    logic capture_w;

    assign stream_w     = (state_q == STREAM);
    assign last_w       = (idx_q == IDX_W'(WINDOW_SIZE - 1));
    assign xfer_w       = stream_w && out_ready;
    // A new window can be taken in the same cycle the last beat leaves, so no bubble.
    assign window_ready = !stream_w || (xfer_w && last_w);
    assign capture_w    = window_valid && window_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            win_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            win_q     <= win_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        win_d     = win_q;
        overrun_d = overrun_q | (window_valid && !window_ready);

        if (capture_w) begin
            win_d = window;
            idx_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (capture_w) state_d = STREAM;
            end
            STREAM: begin
                if (xfer_w) begin
                    if (!last_w) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (!capture_w) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = stream_w;
        busy      = stream_w;
        overrun   = overrun_q;
        out_slice = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        if (stream_w) begin
            out_slice = win_q[idx_q];
            out_idx   = idx_q;
            out_last  = last_w;
        end
    end

endmodule

// File: doc/window_streamer.md
# window_streamer

Consumer-side counterpart of the windower. It captures a completed window (WINDOW_SIZE time slices × NUM_CHS channels × SAMPLE_SIZE bits) when the windower pulses `done`, then replays it one time slice per beat over a valid/ready stream to the downstream encoder. This lets per-sample HDC encoding run serially without holding the windower's parallel bus. It flags any window that arrives while the previous one is still draining.

## Interface
- NUM_CHS, 2, number of channels per time slice
- WINDOW_SIZE, 4, time slices per window (≥2)
- SAMPLE_SIZE, 2, bits per channel sample
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous, active-low reset
- window_valid  input  1  single-cycle pulse, driven by windower `done`
- window  input  [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0]  windower `sample_memory`; `window[0]` is the oldest slice
- window_ready  output  1  block can capture a window this cycle
- out_valid  output  1  `out_slice` holds a valid beat
- out_ready  input  1  downstream accepts the beat
- out_slice  output  [NUM_CHS-1:0][SAMPLE_SIZE-1:0]  current time slice, all channels
- out_idx  output  $clog2(WINDOW_SIZE)  slice index within the window
- out_last  output  1  high when `out_idx == WINDOW_SIZE-1` and `out_valid`
- overrun  output  1  sticky: a window was dropped
- busy  output  1  state is STREAM

## Operation
- Window capture register, index counter, two-state FSM: IDLE, STREAM.
- Handshake: a beat transfers on a rising edge where `out_valid && out_ready`.
- `window_ready = (state==IDLE) || (out_valid && out_ready && out_last)`. This is combinational.
- IDLE: if `window_valid`, capture `window`, set idx=0, go to STREAM. Otherwise stay.
- STREAM: `out_valid=1`, `out_slice = captured[idx]`.
  - Beat transfers with idx<WINDOW_SIZE-1: idx+1.
  - Beat transfers on last slice with `window_valid`: capture the new window, idx=0, stay in STREAM.
  - Beat transfers on last slice without `window_valid`: go to IDLE.
  - No transfer: hold idx, captured data and all outputs.
- Emission order is oldest first: `window[0]`, `window[1]`, …, `window[WINDOW_SIZE-1]`.
- Overrun:
  - `window_valid && !window_ready` sets `overrun`. The incoming window is discarded and the captured window is not modified.
  - `overrun` clears only on reset.
- The counter saturates logically at WINDOW_SIZE-1. It never wraps without a capture.
- `out_slice` and `out_idx` are 0 whenever `out_valid=0`.

## Timing
- Reset values (async, immediate on `nrst`=0): state=IDLE, idx=0, captured=0, `out_valid`=0, `out_slice`=0, `out_idx`=0, `out_last`=0, `overrun`=0, `busy`=0.
- `window_ready` resets to 1.
- Capture latency: `window_valid` sampled at edge N, so `out_valid` is high after edge N (first beat is presentable in cycle N+1).
- Throughput: one slice per cycle while `out_ready`=1. A window needs WINDOW_SIZE cycles minimum.
- Back-to-back windows have no bubble: `out_valid` stays high across the window boundary and `out_idx` goes WINDOW_SIZE-1 → 0.
- With the windower stepping every WINDOW_STEP `en` pulses, no overrun occurs while `out_ready` stays high, provided the `en` period × WINDOW_STEP ≥ WINDOW_SIZE cycles.
- Reset asserted mid-stream aborts the window. No partial beat or `out_last` is emitted afterwards.
- `out_ready` may toggle arbitrarily. Outputs are stable while `out_valid && !out_ready`.

## Test plan
- Reset check: hold `nrst`=0 with `window_valid` pulsing → all outputs are at reset values, `window_ready`=1, and no capture occurs.
- Single window (NUM_CHS=2, SAMPLE_SIZE=2, WINDOW_SIZE=4) with slices t0=01/01, t1=10/10, t2=11/11, t3=00/00, and `out_ready`=1 → beats are 01/01, 10/10, 11/11, 00/00 in consecutive cycles starting one cycle after the pulse, with idx 0..3, `out_last` only on idx 3, then IDLE.
- Backpressure: same window with `out_ready` low on cycles 2 and 3 → slice 10/10 is held for 3 cycles with idx=1 and unchanged data, all 4 beats are delivered in order, and the stream takes 6 cycles.
- Back-to-back: second window (01,10,11,00 → 11,00,01,10 per slice) pulses in the same cycle as the last-beat handshake → `out_valid` never drops, idx goes 3→0, the new data follows, and `overrun` stays 0.
- Overrun: second `window_valid` arrives at idx=1 → `overrun`=1 from the next cycle, the first window completes unchanged, and the second window is never emitted; `overrun` persists until `nrst`=0.
- Mid-stream reset: assert `nrst`=0 at idx=2 → `out_valid`, `busy` and `overrun` go to 0 immediately. After release, a new window streams from idx 0.
